pc_gen: RTL

- Parametrised program-counter generator for the RISC-V fetch stage. It is the next generation of the single-cycle PC register.
- Adds configurable XLEN, reset vector and instruction alignment, plus a valid/ready fetch-request handshake.
- Handles prioritised redirects (trap, JALR, branch/JAL), stall and halt, and emits a flush pulse.
- Sits between the execute/commit redirect logic and the instruction-memory request port.

---
 rtl/pc_gen_pkg.sv | 19 +
 rtl/pc_redirect_mux.sv | 57 +++++
 rtl/pc_gen.sv | 101 ++++++++++
 3 files changed

// File: rtl/pc_gen_pkg.sv
// Shared types and constants for the pc_gen fetch-stage program counter.
package pc_gen_pkg;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HALT
    } pc_state_t;

    typedef enum logic [1:0] {
        TRAP,
        JALR,
        BR,
        NONE
    } redir_src_t;

    localparam int unsigned INST_BYTES = 4;

endpackage

// File: rtl/pc_redirect_mux.sv
// Combinational redirect selection: trap > jalr > branch/JAL, target adders and alignment check.
// Alignment checking is compiled in only when PC_MISALIGN_CHK_EN is defined.
module pc_redirect_mux
    import pc_gen_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned IALIGN = 32
) (
    input  logic            trap_i,
    input  logic [XLEN-1:0] trap_vec_i,
    input  logic            jalr_i,
    input  logic [XLEN-1:0] jalr_base_i,
    input  logic [XLEN-1:0] jalr_off_i,
    input  logic            br_taken_i,
    input  logic [XLEN-1:0] br_base_i,
    input  logic [XLEN-1:0] br_off_i,
    output logic            redir_o,
    output logic [XLEN-1:0] target_o,
    output logic            misalign_o
);

`ifdef PC_MISALIGN_CHK_EN
    localparam logic CHK_EN = 1'b1;
`else
    localparam logic CHK_EN = 1'b0;
`endif

    redir_src_t      src;
    logic [XLEN-1:0] jalr_sum;
    logic [XLEN-1:0] br_sum;
    logic            unaligned;

    assign jalr_sum = jalr_base_i + jalr_off_i;
    assign br_sum   = br_base_i + br_off_i;

    always_comb begin
        src      = NONE;
        target_o = '0;
        if (trap_i) begin
            src      = TRAP;
            target_o = trap_vec_i;
        end else if (jalr_i) begin
            src      = JALR;
            target_o = {jalr_sum[XLEN-1:1], 1'b0};
        end else if (br_taken_i) begin
            src      = BR;
            target_o = br_sum;
        end
    end

    assign redir_o = (src != NONE);

    // Trap and mret targets come from CSRs and are trusted, so only JALR/branch are checked.
    assign unaligned  = (IALIGN == 16) ? target_o[0] : (|target_o[1:0]);
    assign misalign_o = CHK_EN && unaligned && ((src == JALR) || (src == BR));

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage program counter with BOOT/RUN/HALT control, prioritised redirects and a
// valid/ready request port. Optional misaligned-target check: define PC_MISALIGN_CHK_EN.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int unsigned    XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = '0,
    parameter int unsigned    IALIGN    = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall_i,
    input  logic            halt_i,
    input  logic            resume_i,
    input  logic            br_taken_i,
    input  logic [XLEN-1:0] br_base_i,
    input  logic [XLEN-1:0] br_off_i,
    input  logic            jalr_i,
    input  logic [XLEN-1:0] jalr_base_i,
    input  logic [XLEN-1:0] jalr_off_i,
    input  logic            trap_i,
    input  logic [XLEN-1:0] trap_vec_i,
    output logic            req_valid_o,
    input  logic            req_ready_i,
    output logic [XLEN-1:0] req_addr_o,
    output logic            flush_o,
    output logic            halted_o,
    output logic            misalign_o
);

    pc_state_t       state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] target;
    logic            redir;
    logic            misalign;
    logic            flush_q;
    logic            misalign_q;

    pc_redirect_mux #(
        .XLEN   (XLEN),
        .IALIGN (IALIGN)
    ) u_redirect_mux (
        .trap_i      (trap_i),
        .trap_vec_i  (trap_vec_i),
        .jalr_i      (jalr_i),
        .jalr_base_i (jalr_base_i),
        .jalr_off_i  (jalr_off_i),
        .br_taken_i  (br_taken_i),
        .br_base_i   (br_base_i),
        .br_off_i    (br_off_i),
        .redir_o     (redir),
        .target_o    (target),
        .misalign_o  (misalign)
    );

    always_comb begin
        state_d     = state_q;
        req_valid_o = 1'b0;
        unique case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
                req_valid_o = !stall_i;
                if (halt_i && !redir) state_d = HALT;
            end
            HALT: begin
                if (resume_i || redir) state_d = RUN;
            end
            default: state_d = BOOT;
        endcase
    end

    // A rejected (misaligned) redirect still pre-empts the sequential advance.
    always_comb begin
        pc_d = pc_q;
        if (redir) begin
            if (!misalign) pc_d = target;
        end else if (req_valid_o && req_ready_i) begin
            pc_d = pc_q + XLEN'(INST_BYTES);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= BOOT;
            pc_q       <= RESET_VEC;
            flush_q    <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            flush_q    <= redir && !misalign;
            misalign_q <= redir && misalign;
        end
    end

    assign req_addr_o = pc_q;
    assign flush_o    = flush_q;
    assign halted_o   = (state_q == HALT);
    assign misalign_o = misalign_q;

endmodule
